// File: rtl/wb_block_reader.sv
// wb_block_reader: Wishbone pipelined block reader streaming words out as AXI-Stream with tlast.
module wb_block_reader #(
  parameter int CFGAW = 32,
  parameter int CFGDW = 32,
  parameter int LENW = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CFGAW-1:0] base_addr,
  input  logic [LENW-1:0]  length,
  output logic             busy,
  output logic             done,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [CFGAW-1:0] addr_o,
  output logic [CFGDW-1:0] data_o,
  input  logic             ack_i,
  input  logic             stall_i,
  input  logic [CFGDW-1:0] data_i,
  output logic [CFGDW-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [LENW-1:0] len_q, issued_q, received_q, sent_q;
  logic [CFGAW-1:0] addr_q;
  logic done_q;
  logic [CFGDW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [LENW:0] credit;
  logic idle_start, accept, push, pop, last_ack, last_pop;
  // Outstanding reads plus buffered words must fit the FIFO before another read issues.
  assign credit = (LENW+1)'(issued_q - received_q) + (LENW+1)'(cnt_q);
  assign idle_start = state_q == IDLE && start;
  assign cyc_o = state_q == READ;
  assign stb_o = cyc_o && issued_q != len_q && credit < (LENW+1)'(FIFO_DEPTH);
  assign accept = stb_o && !stall_i;
  assign push = ack_i && cyc_o && received_q != issued_q;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign last_ack = push && (received_q + LENW'(1)) == len_q;
  assign last_pop = pop && m_axis_tlast;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign we_o = 1'b0;
  assign data_o = '0;
  assign addr_o = addr_q;
  assign m_axis_tvalid = cnt_q != '0;
  assign m_axis_tdata = mem_q[rd_q];
  assign m_axis_tlast = m_axis_tvalid && sent_q == len_q - LENW'(1);
  always_comb begin
    state_d = state_q == IDLE  ? ((start && length != '0) ? READ : IDLE) :
              state_q == READ  ? (last_ack ? DRAIN : READ) :
              state_q == DRAIN ? (last_pop ? IDLE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      len_q <= '0;
      issued_q <= '0;
      received_q <= '0;
      sent_q <= '0;
      addr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= (idle_start && length == '0) || last_pop;
      if (idle_start) begin
        len_q <= length;
        addr_q <= base_addr;
        issued_q <= '0;
        received_q <= '0;
        sent_q <= '0;
      end else begin
        if (accept) begin
          addr_q <= addr_q + CFGAW'(1);
          issued_q <= issued_q + LENW'(1);
        end
        if (push) received_q <= received_q + LENW'(1);
        if (pop) sent_q <= sent_q + LENW'(1);
      end
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: tb/tb_wb_block_reader.sv
// tb_wb_block_reader: directed checks of wb_block_reader against a 1/2-cycle-latency slave model.
module tb_wb_block_reader;
  logic clk = 0, rst = 1, start = 0, ack_i = 0, stall_i = 0, m_axis_tready = 0;
  logic [31:0] base_addr = 0, data_i = 0;
  logic [15:0] length = 0;
  logic busy, done, cyc_o, stb_o, we_o, m_axis_tvalid, m_axis_tlast;
  logic [31:0] addr_o, data_o, m_axis_tdata;
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 1, st_cyc;
  int n_req, n_str, n_done, n_cyc_hi, n_busy, n_tv, done_cyc, done_busy;
  logic [31:0] req_addr [32], str_data [32];
  int req_cyc [32], str_cyc [32];
  logic str_last [32];
  logic acc, d_ack = 0;
  logic [31:0] sa, d_data = 0;

  wb_block_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .addr_o(addr_o), .data_o(data_o), .ack_i(ack_i), .stall_i(stall_i), .data_i(data_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    acc = stb_o && !stall_i && !rst;
    sa = addr_o;
    @(posedge clk);
    #1;
    if (lat == 1) begin
      ack_i = acc; data_i = f(sa); d_ack = 0;
    end else begin
      ack_i = d_ack; data_i = d_data; d_ack = acc; d_data = f(sa);
    end
  end

  always @(negedge clk) if (!rst) begin
    if (stb_o && !stall_i && n_req < 32) begin
      req_addr[n_req] = addr_o; req_cyc[n_req] = cyc; n_req++;
    end
    if (m_axis_tvalid && m_axis_tready && n_str < 32) begin
      str_data[n_str] = m_axis_tdata; str_last[n_str] = m_axis_tlast; str_cyc[n_str] = cyc; n_str++;
    end
    if (done) begin
      n_done++; done_cyc = cyc; done_busy = busy;
    end
    if (cyc_o) n_cyc_hi++;
    if (busy) n_busy++;
    if (m_axis_tvalid) n_tv++;
  end

  task automatic clear();
    n_req = 0; n_str = 0; n_done = 0; n_cyc_hi = 0; n_busy = 0; n_tv = 0; done_cyc = -1; done_busy = -1;
  endtask

  task automatic go(input logic [31:0] b, input logic [15:0] l);
    clear();
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1; st_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && n_done == 0; k++) @(posedge clk);
    if (n_done == 0) chk("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_stream(input string tag, input logic [31:0] b, input int l);
    chk({tag, "_nstr"}, n_str, l);
    for (int i = 0; i < l && i < n_str; i++) begin
      chk({tag, "_data"}, str_data[i], f(b + i));
      chk({tag, "_last"}, str_last[i], i == l - 1);
    end
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0); chk("rst_addr", addr_o, 0); chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0); chk("we_tied", we_o, 0); chk("data_o_tied", data_o, 0);
    @(posedge clk); #1; rst = 0;

    // basic block, 1-cycle slave
    lat = 1; m_axis_tready = 1;
    go(32'h10, 4);
    wait_done();
    chk("t1_nreq", n_req, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", req_addr[i], 32'h10 + i);
      chk("t1_req_cyc", req_cyc[i], st_cyc + 1 + i);
    end
    chk("t1_first_tvalid", str_cyc[0], req_cyc[0] + 2);
    chk_stream("t1", 32'h10, 4);
    chk("t1_done_cyc", done_cyc, str_cyc[3] + 1);
    chk("t1_done_busy", done_busy, 0);

    // backpressure with 2-cycle slave: credit caps issue at FIFO depth
    lat = 2; m_axis_tready = 0;
    go(32'h100, 8);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t2_nreq_held", n_req, 4);
    chk("t2_stb_low", stb_o, 0);
    chk("t2_cyc_high", cyc_o, 1);
    chk("t2_tvalid", m_axis_tvalid, 1);
    @(posedge clk); #1; m_axis_tready = 1;
    wait_done();
    chk("t2_nreq", n_req, 8);
    for (int i = 0; i < 8; i++) chk("t2_addr", req_addr[i], 32'h100 + i);
    chk_stream("t2", 32'h100, 8);

    // stall mid-block holds request
    lat = 1;
    go(32'h200, 6);
    @(posedge clk); #1; stall_i = 1;
    @(negedge clk);
    sa = addr_o;
    chk("t3_stall_stb", stb_o, 1);
    repeat (2) begin
      @(negedge clk);
      chk("t3_stall_stb_hold", stb_o, 1);
      chk("t3_stall_addr_hold", addr_o, sa);
    end
    @(posedge clk); #1; stall_i = 0;
    wait_done();
    chk("t3_nreq", n_req, 6);
    for (int i = 0; i < 6; i++) chk("t3_addr", req_addr[i], 32'h200 + i);
    chk_stream("t3", 32'h200, 6);

    // zero length
    go(32'h300, 0);
    wait_done();
    chk("t4_ndone", n_done, 1);
    chk("t4_done_cyc", done_cyc, st_cyc + 1);
    chk("t4_cyc_hi", n_cyc_hi, 0);
    chk("t4_busy", n_busy, 0);
    chk("t4_tvalid", n_tv, 0);
    chk("t4_nreq", n_req, 0);

    // address wrap
    go(32'hFFFF_FFFE, 4);
    wait_done();
    chk("t5_nreq", n_req, 4);
    chk("t5_a0", req_addr[0], 32'hFFFF_FFFE);
    chk("t5_a1", req_addr[1], 32'hFFFF_FFFF);
    chk("t5_a2", req_addr[2], 32'h0000_0000);
    chk("t5_a3", req_addr[3], 32'h0000_0001);
    chk_stream("t5", 32'hFFFF_FFFE, 4);

    // reset mid-block with reads outstanding and one word buffered
    lat = 2; m_axis_tready = 0;
    go(32'h400, 8);
    begin
      int k;
      for (k = 0; k < 50 && !m_axis_tvalid; k++) @(negedge clk);
      if (!m_axis_tvalid) chk("t6_tvalid_timeout", 0, 1);
    end
    rst = 1;
    @(posedge clk); #1;
    chk("t6_cyc", cyc_o, 0); chk("t6_stb", stb_o, 0); chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_busy", busy, 0); chk("t6_done", done, 0);
    rst = 0;
    clear();
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_done", n_done, 0);
    chk("t6_idle_tvalid", n_tv, 0);
    lat = 1; m_axis_tready = 1;
    go(32'h40, 3);
    wait_done();
    chk("t6_nreq", n_req, 3);
    chk_stream("t6", 32'h40, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
